spram_fifo_ctrl: RTL and testbench

Sequences one single-port 32-bit RAM (1-cycle read latency, read_valid strobe) as a FIFO. It arbitrates between a push port and a pop port, because the RAM takes only one access per cycle. It owns the read/write pointers, occupancy and full/empty flags, and registers the RAM read data into a pop-data output. It sits between the FIFO top level and the RAM instance inside fifo_with_spram.

---
 rtl/spram_fifo_ctrl_pkg.sv | 12 +
 rtl/spram_rr_arb.sv | 45 ++++
 rtl/spram_fifo_ctrl.sv | 105 ++++++++++
 tb/tb_spram_fifo_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_fifo_ctrl_pkg.sv
// Shared types and parameter defaults for the single-port-RAM FIFO controller.
package spram_fifo_ctrl_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

endpackage

// File: rtl/spram_rr_arb.sv
// Two-requester round-robin arbiter for the single RAM port: combinational grant, no latency.
// Both requesting -> the side not granted last wins; block suppresses all grants.
module spram_rr_arb
  import spram_fifo_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic block,
  input  logic req_w,
  input  logic req_r,
  output logic gnt_w,
  output logic gnt_r
);

  grant_e last_grant;

  always_comb begin
    gnt_w = 1'b0;
    gnt_r = 1'b0;
    if (!block) begin
      if (req_w && req_r) begin
        if (last_grant == GRANT_READ) begin
          gnt_w = 1'b1;
        end else begin
          gnt_r = 1'b1;
        end
      end else begin
        gnt_w = req_w;
        gnt_r = req_r;
      end
    end
  end

  // Only a real grant moves the round-robin state, so flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_READ;
    end else if (gnt_w) begin
      last_grant <= GRANT_WRITE;
    end else if (gnt_r) begin
      last_grant <= GRANT_READ;
    end
  end

endmodule

// File: rtl/spram_fifo_ctrl.sv
// FIFO sequencer over a 1-cycle-latency single-port RAM; pop data valid 2 cycles after rd_ready.
// Push/pop stall via combinational wr_ready/rd_ready: full blocks writes, empty blocks reads.
module spram_fifo_ctrl
  import spram_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_read_valid
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_pending;
  logic              gnt_w;
  logic              gnt_r;
  logic              want_w;
  logic              want_r;
  logic              rd_capture;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign want_w = wr_valid & ~full;
  assign want_r = rd_req & ~empty;

  // Grants are also held off while reset is asserted so outputs are quiet immediately.
  spram_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .block (flush | ~rst_n),
    .req_w (want_w),
    .req_r (want_r),
    .gnt_w (gnt_w),
    .gnt_r (gnt_r)
  );

  assign wr_ready = gnt_w;
  assign rd_ready = gnt_r;

  always_comb begin
    ram_ena  = gnt_w | gnt_r;
    ram_wea  = gnt_w;
    ram_addr = gnt_w ? wr_ptr : rd_ptr;
    ram_din  = wr_data;
  end

  // A read strobe only counts when we actually issued the read the cycle before.
  assign rd_capture = rd_pending & ram_read_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rd_pending    <= 1'b0;
      rd_data_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rd_pending    <= 1'b0;
      rd_data_valid <= 1'b0;
    end else begin
      if (gnt_w) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        count  <= count + (ADDR_W+1)'(1);
      end else if (gnt_r) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        count  <= count - (ADDR_W+1)'(1);
      end
      rd_pending    <= gnt_r;
      rd_data_valid <= rd_capture;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (!flush && rd_capture) begin
      rd_data <= ram_dout;
    end
  end

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Bench for spram_fifo_ctrl: behavioural RAM, reference model of grants/occupancy,
// and a scoreboard of expected pop data with its due cycle.
module tb_spram_fifo_ctrl;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_req;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              ram_ena;
  logic              ram_wea;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_read_valid;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic              rv_q;
  logic              inj;

  spram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .rd_req         (rd_req),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .rd_data_valid  (rd_data_valid),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .ram_ena        (ram_ena),
    .ram_wea        (ram_wea),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout),
    .ram_read_valid (ram_read_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addr] <= ram_din;
    if (ram_ena && !ram_wea) ram_q <= mem[ram_addr];
    rv_q <= ram_ena && !ram_wea;
  end
  assign ram_dout       = ram_q;
  assign ram_read_valid = rv_q | inj;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DATA_W-1:0] d;
    int                c;
  } ret_t;

  int                mcount;
  logic [ADDR_W-1:0] mwp;
  logic [ADDR_W-1:0] mrp;
  bit                mlast_w;
  logic [DATA_W-1:0] mfifo [$];
  ret_t              rq [$];
  int                cyc;
  bit                eg_w;
  bit                eg_r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic monitor_cycle();
    bit                ww;
    bit                wrr;
    bit                exp_v;
    int                ecount;
    logic [ADDR_W-1:0] erp;
    if (!rst_n) begin
      eg_w = 1'b0;
      eg_r = 1'b0;
    end else begin
      ww  = wr_valid && (mcount != DEPTH);
      wrr = rd_req && (mcount != 0);
      if (flush) begin
        eg_w = 1'b0;
        eg_r = 1'b0;
      end else if (ww && wrr) begin
        eg_w = !mlast_w;
        eg_r = mlast_w;
      end else begin
        eg_w = ww;
        eg_r = wrr;
      end
    end
    ecount = rst_n ? mcount : 0;
    erp    = rst_n ? mrp : '0;
    chk("wr_ready", 32'(wr_ready), 32'(eg_w));
    chk("rd_ready", 32'(rd_ready), 32'(eg_r));
    chk("ram_ena", 32'(ram_ena), 32'(eg_w | eg_r));
    chk("ram_wea", 32'(ram_wea), 32'(eg_w));
    chk("ram_addr", 32'(ram_addr), 32'(eg_w ? mwp : erp));
    if (eg_w) chk("ram_din", ram_din, wr_data);
    chk("count", 32'(count), 32'(ecount));
    chk("full", 32'(full), 32'(ecount == DEPTH));
    chk("empty", 32'(empty), 32'(ecount == 0));
    exp_v = rst_n && (rq.size() > 0) && ((cyc - rq[0].c) == 2);
    chk("rd_vld", 32'(rd_data_valid), 32'(exp_v));
    if (exp_v) chk("rd_data", rd_data, rq[0].d);
    if (!rst_n) chk("rd_data_rst", rd_data, 32'h0);
  endtask

  task automatic model_update();
    ret_t r;
    if (!rst_n) begin
      mcount  = 0;
      mwp     = '0;
      mrp     = '0;
      mlast_w = 1'b0;
      mfifo.delete();
      rq.delete();
    end else begin
      if (rq.size() > 0 && (cyc - rq[0].c) == 2) void'(rq.pop_front());
      if (flush) begin
        mcount = 0;
        mwp    = '0;
        mrp    = '0;
        mfifo.delete();
        rq.delete();
      end else if (eg_w) begin
        mfifo.push_back(wr_data);
        mwp++;
        mcount++;
        mlast_w = 1'b1;
      end else if (eg_r) begin
        r.d = mfifo.pop_front();
        r.c = cyc;
        rq.push_back(r);
        mrp++;
        mcount--;
        mlast_w = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_req = 1'b0; inj = 1'b0;
    mcount = 0; mwp = '0; mrp = '0; mlast_w = 1'b0; cyc = 0; eg_w = 1'b0; eg_r = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;

    // Fill to full, then a 5th push must stall.
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = 32'hA0 + i;
      #1 chk("push_addr", 32'(ram_addr), 32'(i));
      cycle();
    end
    wr_data = 32'hA4;
    #1;
    chk("full_at4", 32'(full), 32'h1);
    chk("count_at4", 32'(count), 32'h4);
    chk("wr_ready_full", 32'(wr_ready), 32'h0);
    cycle();
    wr_valid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1;
      #1 chk("pop_addr", 32'(ram_addr), 32'(i));
      cycle();
    end
    rd_req = 1'b0;
    repeat (3) cycle();
    chk("empty_after_pops", 32'(empty), 32'h1);

    // Load 3, pop 1 so last grant is READ with 2 entries, then contend.
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 32'hB0 + i; cycle();
    end
    wr_valid = 1'b0; rd_req = 1'b1; cycle();
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1; rd_req = 1'b1; wr_data = 32'hB3 + i;
      #1;
      chk("alt_w", 32'(wr_ready), 32'(i % 2 == 0));
      chk("cnt_range", 32'(count >= 2 && count <= 3), 32'h1);
      cycle();
    end
    wr_valid = 1'b0;
    repeat (4) cycle();
    rd_req = 1'b0;
    repeat (3) cycle();

    // Pointer wrap from a clean start.
    flush = 1'b1; cycle(); flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1; wr_data = 32'hC0 + i;
      #1 chk("wrap_waddr", 32'(ram_addr), 32'(i % 4));
      cycle();
      wr_valid = 1'b0; rd_req = 1'b1; cycle(); rd_req = 1'b0;
    end
    repeat (3) cycle();

    // Flush the cycle after a read grant discards the return.
    wr_valid = 1'b1; wr_data = 32'hD0; cycle();
    wr_data = 32'hD1; cycle();
    wr_valid = 1'b0; rd_req = 1'b1; cycle();
    rd_req = 1'b0; flush = 1'b1; cycle();
    flush = 1'b0;
    #1;
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_empty", 32'(empty), 32'h1);
    repeat (3) cycle();
    wr_valid = 1'b1; wr_data = 32'hE0;
    #1 chk("post_flush_addr", 32'(ram_addr), 32'h0);
    cycle();
    wr_valid = 1'b0;

    // Async reset with a read in flight, then stray read strobes.
    wr_valid = 1'b1; wr_data = 32'hF0; cycle();
    wr_data = 32'hF1; cycle();
    wr_valid = 1'b0; rd_req = 1'b1; cycle();
    rd_req = 1'b0; wr_valid = 1'b1; wr_data = 32'hF2;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_ready", 32'(wr_ready), 32'h0);
    chk("arst_rd_ready", 32'(rd_ready), 32'h0);
    chk("arst_ram_ena", 32'(ram_ena), 32'h0);
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_full", 32'(full), 32'h0);
    chk("arst_empty", 32'(empty), 32'h1);
    chk("arst_rd_vld", 32'(rd_data_valid), 32'h0);
    chk("arst_rd_data", rd_data, 32'h0);
    inj = 1'b1; wr_valid = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (2) cycle();
    inj = 1'b0;
    repeat (3) cycle();
    chk("scoreboard_drained", 32'(rq.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
